// File: rtl/pcileech_unlock_ctrl.sv
// Unlock controller for the pcileech com link: a MAGIC header arms a one-shot
// command window; repeated bad commands put the link into a timed lockout.
module pcileech_unlock_ctrl #(
  parameter logic [31:0] CODE_MAGIC     = 32'h55AAC0DE,
  parameter logic [31:0] CODE_ENABLE    = 32'h49901330,
  parameter logic [31:0] CODE_INT       = 32'h52322313,
  parameter logic [31:0] CODE_DISABLE   = 32'hF2F2D2D2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd500000000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic [3:0]  tx_be_in,
  output logic [3:0]  tx_be_out,
  output logic        activated,
  output logic        int_enable,
  output logic [1:0]  state_o,
  output logic        cmd_ack,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  localparam logic [31:0] TO_LAST   = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] LOCK_LAST = LOCKOUT_CYCLES - 32'd1;
  localparam logic [1:0]  FAIL_LIM  = 2'(MAX_FAILS);

  state_t      r_state;
  logic [31:0] r_timer;
  logic [1:0]  r_fails;
  logic        r_act;
  logic        r_ie;
  logic        r_ack;
  logic        r_err;

  logic [1:0]  w_fails_inc;
  logic        w_is_cmd;

  assign w_fails_inc = (r_fails == 2'd3) ? 2'd3 : r_fails + 2'd1;
  assign w_is_cmd    = (rx_data == CODE_ENABLE) || (rx_data == CODE_INT) ||
                       (rx_data == CODE_DISABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= 32'd0;
      r_fails <= 2'd0;
      r_act   <= 1'b1;
      r_ie    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid && rx_data == CODE_MAGIC) begin
            r_state <= S_ARMED;
            r_timer <= 32'd0;
          end
        end
        S_ARMED: begin
          // A valid word always wins over a coincident timeout.
          if (rx_valid) begin
            if (rx_data == CODE_MAGIC) begin
              r_timer <= 32'd0;
            end else if (w_is_cmd) begin
              if (rx_data == CODE_ENABLE) r_act <= 1'b1;
              if (rx_data == CODE_INT)    r_ie  <= 1'b1;
              if (rx_data == CODE_DISABLE) begin
                r_act <= 1'b0;
                r_ie  <= 1'b0;
              end
              r_ack   <= 1'b1;
              r_fails <= 2'd0;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_fails <= w_fails_inc;
              r_timer <= 32'd0;
              r_state <= (w_fails_inc == FAIL_LIM) ? S_LOCK : S_IDLE;
            end
          end else if (r_timer == TO_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_LOCK: begin
          if (r_timer == LOCK_LAST) begin
            r_state <= S_IDLE;
            r_fails <= 2'd0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_be_out  = r_act ? tx_be_in : 4'b0000;
  assign activated  = r_act;
  assign int_enable = r_ie;
  assign state_o    = r_state;
  assign cmd_ack    = r_ack;
  assign cmd_err    = r_err;

endmodule

// File: tb/tb_pcileech_unlock_ctrl.sv
// Bench for pcileech_unlock_ctrl: directed literal checks plus random traffic
// compared every cycle against an elapsed-time behavioural model.
module tb_pcileech_unlock_ctrl;
  localparam logic [31:0] MAGIC = 32'h55AAC0DE;
  localparam logic [31:0] C_EN  = 32'h49901330;
  localparam logic [31:0] C_INT = 32'h52322313;
  localparam logic [31:0] C_DIS = 32'hF2F2D2D2;
  localparam int T = 16;
  localparam int L = 32;
  localparam int MAXF = 3;

  logic clk = 0, rst_n = 0;
  logic [31:0] rx_data = 0;
  logic rx_valid = 0;
  logic [3:0] tx_be_in = 4'hF, tx_be_out;
  logic activated, int_enable, cmd_ack, cmd_err;
  logic [1:0] state_o;

  pcileech_unlock_ctrl #(
    .TIMEOUT_CYCLES(32'd16), .LOCKOUT_CYCLES(32'd32), .MAX_FAILS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_be_in(tx_be_in), .tx_be_out(tx_be_out), .activated(activated),
    .int_enable(int_enable), .state_o(state_o), .cmd_ack(cmd_ack), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: mode 0/1/2, elapsed edges since the current window opened.
  int m_mode, m_el, m_fails;
  bit m_act, m_ie, m_ack, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_el = 0; m_fails = 0;
      m_act = 1; m_ie = 0; m_ack = 0; m_err = 0;
    end else begin
      m_ack = 0; m_err = 0;
      if (m_mode == 0) begin
        if (rx_valid && rx_data == MAGIC) begin m_mode = 1; m_el = 0; end
      end else if (m_mode == 1) begin
        if (rx_valid) begin
          if (rx_data == MAGIC) m_el = 0;
          else if (rx_data == C_EN)  begin m_act = 1; m_ack = 1; m_fails = 0; m_mode = 0; end
          else if (rx_data == C_INT) begin m_ie = 1; m_ack = 1; m_fails = 0; m_mode = 0; end
          else if (rx_data == C_DIS) begin m_act = 0; m_ie = 0; m_ack = 1; m_fails = 0; m_mode = 0; end
          else begin
            m_err = 1;
            m_fails = (m_fails >= 3) ? 3 : m_fails + 1;
            if (m_fails == MAXF) begin m_mode = 2; m_el = 0; end else m_mode = 0;
          end
        end else begin
          m_el++;
          if (m_el == T) m_mode = 0;
        end
      end else begin
        m_el++;
        if (m_el == L) begin m_mode = 0; m_fails = 0; end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_state", {30'd0, state_o}, m_mode);
    chk("model_act", {31'd0, activated}, {31'd0, m_act});
    chk("model_ie", {31'd0, int_enable}, {31'd0, m_ie});
    chk("model_ack", {31'd0, cmd_ack}, {31'd0, m_ack});
    chk("model_err", {31'd0, cmd_err}, {31'd0, m_err});
    chk("model_be", {28'd0, tx_be_out}, m_act ? {28'd0, tx_be_in} : 32'd0);
    chk("ack_err_excl", {31'd0, cmd_ack & cmd_err}, 32'd0);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drv(input logic v, input logic [31:0] d);
    rx_valid = v; rx_data = d;
  endtask

  task automatic send(input logic [31:0] d);
    drv(1, d); tick();
  endtask

  int pv;
  int r;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    chk("rst_act", {31'd0, activated}, 1);
    chk("rst_ie", {31'd0, int_enable}, 0);
    chk("rst_be", {28'd0, tx_be_out}, 4'hF);
    chk("rst_state", {30'd0, state_o}, 0);

    send(MAGIC); send(C_DIS);
    chk("dis_ack", {31'd0, cmd_ack}, 1);
    chk("dis_act", {31'd0, activated}, 0);
    chk("dis_be", {28'd0, tx_be_out}, 0);
    send(MAGIC); send(C_EN);
    chk("en_act", {31'd0, activated}, 1);

    send(MAGIC); send(C_INT);
    chk("int_ie", {31'd0, int_enable}, 1);
    chk("int_act", {31'd0, activated}, 1);
    send(C_INT);
    chk("lone_int_ack", {31'd0, cmd_ack | cmd_err}, 0);
    chk("lone_int_state", {30'd0, state_o}, 0);

    send(MAGIC); drv(0, 0);
    repeat (15) tick();
    chk("to_still_armed", {30'd0, state_o}, 1);
    tick();
    chk("to_idle", {30'd0, state_o}, 0);
    send(MAGIC); drv(0, 0);
    repeat (15) tick();
    send(C_EN);
    chk("to_edge_ack", {31'd0, cmd_ack}, 1);

    send(MAGIC); send(C_DIS);
    for (int i = 0; i < 3; i++) begin
      send(MAGIC); send(32'h12345678);
      chk("bad_err", {31'd0, cmd_err}, 1);
    end
    chk("lock_state", {30'd0, state_o}, 2);
    send(MAGIC); send(C_EN);
    chk("lock_no_ack", {31'd0, cmd_ack}, 0);
    chk("lock_act_hold", {31'd0, activated}, 0);
    drv(0, 0);
    repeat (29) tick();
    chk("lock_still", {30'd0, state_o}, 2);
    tick();
    chk("lock_exit", {30'd0, state_o}, 0);

    send(MAGIC); drv(0, 0);
    chk("pre_rst_armed", {30'd0, state_o}, 1);
    rst_n = 0; #1;
    chk("mid_rst_state", {30'd0, state_o}, 0);
    chk("mid_rst_pulse", {31'd0, cmd_ack | cmd_err}, 0);
    chk("mid_rst_act", {31'd0, activated}, 1);
    tick(); rst_n = 1;

    pv = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        r = $urandom_range(0, 2);
        pv = (r == 0) ? 4 : (r == 1) ? 50 : 90;
      end
      tx_be_in = 4'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0; tick(); rst_n = 1;
      end
      if ($urandom_range(0, 99) < pv) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: drv(1, MAGIC);
          3: drv(1, C_EN);
          4: drv(1, C_INT);
          5: drv(1, C_DIS);
          default: drv(1, $urandom);
        endcase
      end else drv(0, $urandom);
      tick();
    end
    drv(0, 0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pcileech_unlock_ctrl.md
PCILEECH_UNLOCK_CTRL -- requirements
Module: pcileech_unlock_ctrl

Interface
REQ-001 SHALL have parameter CODE_MAGIC, default 32'h55AAC0DE, meaning the header word that arms command capture.
REQ-002 SHALL have parameter CODE_ENABLE, default 32'h49901330, meaning the command that sets activation.
REQ-003 SHALL have parameter CODE_INT, default 32'h52322313, meaning the command that sets interrupt enable.
REQ-004 SHALL have parameter CODE_DISABLE, default 32'hF2F2D2D2, meaning the command that clears activation and interrupt enable.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning the ARMED window in clk cycles (range 2..2^32-1).
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default 500000000, meaning the LOCKOUT duration in clk cycles (range 2..2^32-1).
REQ-007 SHALL have parameter MAX_FAILS, default 3, meaning the number of consecutive bad commands that triggers LOCKOUT (range 1..3).
REQ-008 SHALL have clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-009 SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have rx_data, input, 32 bits: a received com word.
REQ-011 SHALL have rx_valid, input, 1 bit: rx_data is valid this cycle; no backpressure.
REQ-012 SHALL have tx_be_in, input, 4 bits: byte enables from the com core.
REQ-013 SHALL have tx_be_out, output, 4 bits: gated byte enables to the pads.
REQ-014 SHALL have activated, output, 1 bit: activation status; also drives the LED.
REQ-015 SHALL have int_enable, output, 1 bit: interrupt enable passed to the PCIe core.
REQ-016 SHALL have state_o, output, 2 bits: encoded as IDLE=0, ARMED=1, LOCKOUT=2.
REQ-017 SHALL have cmd_ack, output, 1 bit: one-cycle pulse for a valid command.
REQ-018 SHALL have cmd_err, output, 1 bit: one-cycle pulse for a bad command.

Function
REQ-019 SHALL compute tx_be_out = activated ? tx_be_in : 4'b0000, combinationally with no added latency.
REQ-020 SHALL drive all other outputs from registers.
REQ-021 SHALL act on a word only in a cycle where rx_valid=1.
REQ-022 IDLE: rx_data==CODE_MAGIC -> ARMED next cycle with timer cleared; any other word SHALL be ignored.
REQ-023 ARMED, valid word CODE_ENABLE/CODE_INT/CODE_DISABLE: apply the command, pulse cmd_ack, clear the fail count, return to IDLE; all on the next edge.
REQ-024 Command effects: ENABLE sets activated=1; INT sets int_enable=1 and leaves activated unchanged; DISABLE clears both to 0.
REQ-025 ARMED, valid word CODE_MAGIC: stay ARMED and restart the timer; not a fail.
REQ-026 ARMED, any other valid word: pulse cmd_err and increment the fail count (saturating 2-bit); if the new count equals MAX_FAILS -> LOCKOUT with timer cleared, else -> IDLE.
REQ-027 ARMED timer: increments each cycle without rx_valid; on reaching TIMEOUT_CYCLES-1 -> IDLE with no cmd_err and fail count unchanged.
REQ-028 Timer expiry coinciding with rx_valid: the word SHALL be processed per REQ-023/025/026 and the timeout SHALL be ignored.
REQ-029 LOCKOUT: all rx words ignored (no ack/err); timer increments every cycle; at LOCKOUT_CYCLES-1 -> IDLE and fail count cleared.
REQ-030 activated and int_enable SHALL hold their values through LOCKOUT and through timeouts.
REQ-031 cmd_ack and cmd_err SHALL be mutually exclusive and never high for two consecutive cycles from a single word.
REQ-032 Timer SHALL be 32 bits and SHALL never wrap, because the state always exits before overflow.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, activated=1, int_enable=0, cmd_ack=0, cmd_err=0, timer=0, fail count=0.
REQ-034 Reset asserted mid-ARMED or mid-LOCKOUT SHALL abandon the sequence with no pulse.
REQ-035 The first word SHALL be acted on at the first clk edge after rst_n deasserts.

Verification (TIMEOUT_CYCLES=16, LOCKOUT_CYCLES=32, MAX_FAILS=3)
REQ-036 Reset release, tx_be_in=4'hF -> activated=1, int_enable=0, tx_be_out=4'hF, state_o=0.
REQ-037 Words MAGIC, F2F2D2D2 -> cmd_ack pulse, activated=0, tx_be_out=0; then MAGIC, 49901330 -> activated=1.
REQ-038 Words MAGIC, 52322313 -> int_enable=1, activated unchanged; a lone 52322313 in IDLE -> no change, no pulse.
REQ-039 MAGIC, then no valid for 15 cycles -> state_o=0 on cycle 16; MAGIC with valid 49901330 on the 16th cycle -> cmd_ack.
REQ-040 Three MAGIC+12345678 pairs -> three cmd_err pulses, state_o=2; MAGIC+49901330 inside 32 cycles ignored; state_o=0 after 32 cycles.
REQ-041 rst_n pulsed low while ARMED -> state_o=0 immediately, no cmd_ack/cmd_err, activated=1.
